// File: rtl/huff_pkg.sv
// Shared definitions for the Huffman block scheduler: block size, FSM states,
// zigzag scan tables and the default end-of-block code.
package huff_pkg;

  localparam int unsigned BLK_N = 64;

  localparam logic [15:0] EOB_CODE_DEF = 16'h000A;

  typedef enum logic [1:0] {
    LOAD,
    EMIT,
    EOB
  } state_e;

  // Zigzag scan position -> raster index of an 8x8 block.
  localparam logic [5:0] ZZ_TO_RASTER [BLK_N] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  // Raster index -> zigzag scan position (inverse of the table above).
  localparam logic [5:0] RASTER_TO_ZZ [BLK_N] = '{
    6'd0,  6'd1,  6'd5,  6'd6,  6'd14, 6'd15, 6'd27, 6'd28,
    6'd2,  6'd4,  6'd7,  6'd13, 6'd16, 6'd26, 6'd29, 6'd42,
    6'd3,  6'd8,  6'd12, 6'd17, 6'd25, 6'd30, 6'd41, 6'd43,
    6'd9,  6'd11, 6'd18, 6'd24, 6'd31, 6'd40, 6'd44, 6'd53,
    6'd10, 6'd19, 6'd23, 6'd32, 6'd39, 6'd45, 6'd52, 6'd54,
    6'd20, 6'd22, 6'd33, 6'd38, 6'd46, 6'd51, 6'd55, 6'd60,
    6'd21, 6'd34, 6'd37, 6'd47, 6'd50, 6'd56, 6'd59, 6'd61,
    6'd35, 6'd36, 6'd48, 6'd49, 6'd57, 6'd58, 6'd62, 6'd63
  };

endpackage

// File: rtl/huff_zigzag_rom.sv
// Combinational zigzag lookup; TO_RASTER selects zz->raster, otherwise raster->zz.
module huff_zigzag_rom
  import huff_pkg::*;
#(
  parameter bit TO_RASTER = 1'b1
) (
  input  logic [5:0] idx_in,
  output logic [5:0] idx_out
);

  always_comb begin
    idx_out = TO_RASTER ? ZZ_TO_RASTER[idx_in] : RASTER_TO_ZZ[idx_in];
  end

endmodule

// File: rtl/huff_block_scheduler.sv
// Buffers one raster-order 8x8 block, then replays it in zigzag order through
// the shared Huffman encoder, truncating after the last nonzero and adding EOB.
module huff_block_scheduler
  import huff_pkg::*;
#(
  parameter int unsigned       COEF_W   = 32,
  parameter int unsigned       CODE_W   = 16,
  parameter logic [CODE_W-1:0] EOB_CODE = CODE_W'(EOB_CODE_DEF)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [COEF_W-1:0] coef_in,
  input  logic              coef_valid,
  output logic              coef_ready,
  output logic [15:0]       enc_sym,
  input  logic [CODE_W-1:0] enc_code,
  output logic [CODE_W-1:0] code_out,
  output logic              code_valid,
  input  logic              code_ready,
  output logic              code_is_eob,
  output logic              block_done
);

  state_e            state_q, state_d;
  logic [5:0]        load_cnt_q, load_cnt_d;
  logic [5:0]        scan_cnt_q, scan_cnt_d;
  logic [5:0]        last_nz_q, last_nz_d;
  logic              sym_vld_q, sym_vld_d;
  logic [15:0]       enc_sym_q, enc_sym_d;
  logic [CODE_W-1:0] code_out_q, code_out_d;
  logic              code_valid_q, code_valid_d;
  logic              code_is_eob_q, code_is_eob_d;
  logic              code_final_q, code_final_d;

  logic [15:0]        buf_q [BLK_N];
  logic               buf_we;
  logic [15:0]        coef_sym;
  logic [COEF_W-17:0] unused_coef_lsbs;
  logic [5:0]         load_zz;
  logic [5:0]         scan_addr;
  logic [5:0]         scan_raster;
  logic               out_free;

  assign coef_sym         = coef_in[COEF_W-1 -: 16];
  assign unused_coef_lsbs = coef_in[COEF_W-17:0];
  assign out_free         = !code_valid_q || code_ready;

  // enc_sym is registered: while a symbol is staged, the ROM looks one
  // position ahead so the next symbol is ready as the current code is taken.
  assign scan_addr = sym_vld_q ? scan_cnt_q + 6'd1 : scan_cnt_q;

  huff_zigzag_rom #(.TO_RASTER(1'b0)) u_load_rom (
    .idx_in  (load_cnt_q),
    .idx_out (load_zz)
  );

  huff_zigzag_rom #(.TO_RASTER(1'b1)) u_scan_rom (
    .idx_in  (scan_addr),
    .idx_out (scan_raster)
  );

  always_comb begin
    state_d       = state_q;
    load_cnt_d    = load_cnt_q;
    scan_cnt_d    = scan_cnt_q;
    last_nz_d     = last_nz_q;
    sym_vld_d     = sym_vld_q;
    enc_sym_d     = enc_sym_q;
    code_out_d    = code_out_q;
    code_valid_d  = code_valid_q;
    code_is_eob_d = code_is_eob_q;
    code_final_d  = code_final_q;
    buf_we        = 1'b0;

    if (code_valid_q && code_ready) begin
      code_valid_d = 1'b0;
    end

    case (state_q)
      LOAD: begin
        if (coef_valid) begin
          buf_we     = 1'b1;
          load_cnt_d = load_cnt_q + 6'd1;
          if (coef_sym != '0 && load_zz > last_nz_q) begin
            last_nz_d = load_zz;
          end
          if (load_cnt_q == 6'd63) begin
            state_d    = EMIT;
            load_cnt_d = '0;
            scan_cnt_d = '0;
            sym_vld_d  = 1'b0;
          end
        end
      end

      EMIT: begin
        if (!sym_vld_q) begin
          enc_sym_d = buf_q[scan_raster];
          sym_vld_d = 1'b1;
        end else if (out_free) begin
          code_out_d    = enc_code;
          code_valid_d  = 1'b1;
          code_is_eob_d = 1'b0;
          code_final_d  = (scan_cnt_q == last_nz_q) && (last_nz_q == 6'd63);
          scan_cnt_d    = scan_cnt_q + 6'd1;
          enc_sym_d     = buf_q[scan_raster];
          if (scan_cnt_q == last_nz_q) begin
            sym_vld_d = 1'b0;
            if (last_nz_q == 6'd63) begin
              state_d   = LOAD;
              last_nz_d = '0;
            end else begin
              state_d = EOB;
            end
          end
        end
      end

      EOB: begin
        if (out_free) begin
          code_out_d    = EOB_CODE;
          code_valid_d  = 1'b1;
          code_is_eob_d = 1'b1;
          code_final_d  = 1'b1;
          state_d       = LOAD;
          last_nz_d     = '0;
        end
      end

      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= LOAD;
      load_cnt_q    <= '0;
      scan_cnt_q    <= '0;
      last_nz_q     <= '0;
      sym_vld_q     <= 1'b0;
      enc_sym_q     <= '0;
      code_out_q    <= '0;
      code_valid_q  <= 1'b0;
      code_is_eob_q <= 1'b0;
      code_final_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      load_cnt_q    <= load_cnt_d;
      scan_cnt_q    <= scan_cnt_d;
      last_nz_q     <= last_nz_d;
      sym_vld_q     <= sym_vld_d;
      enc_sym_q     <= enc_sym_d;
      code_out_q    <= code_out_d;
      code_valid_q  <= code_valid_d;
      code_is_eob_q <= code_is_eob_d;
      code_final_q  <= code_final_d;
    end
  end

  always_ff @(posedge clk) begin
    if (buf_we) begin
      buf_q[load_cnt_q] <= coef_sym;
    end
  end

  assign coef_ready  = (state_q == LOAD);
  assign enc_sym     = enc_sym_q;
  assign code_out    = code_out_q;
  assign code_valid  = code_valid_q;
  assign code_is_eob = code_is_eob_q;
  assign block_done  = code_valid_q && code_ready && code_final_q && !rst;

endmodule

// File: tb/tb_huff_block_scheduler.sv
// Self-checking bench for huff_block_scheduler with a stub encoder and a
// queue-based model of the expected code stream per block.
module tb_huff_block_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] coef_in;
  logic        coef_valid;
  logic        coef_ready;
  logic [15:0] enc_sym;
  logic [15:0] enc_code;
  logic [15:0] code_out;
  logic        code_valid;
  logic        code_ready = 1'b1;
  logic        code_is_eob;
  logic        block_done;

  always #5 clk = ~clk;

  huff_block_scheduler #(
    .COEF_W   (32),
    .CODE_W   (16),
    .EOB_CODE (16'h000A)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .coef_in     (coef_in),
    .coef_valid  (coef_valid),
    .coef_ready  (coef_ready),
    .enc_sym     (enc_sym),
    .enc_code    (enc_code),
    .code_out    (code_out),
    .code_valid  (code_valid),
    .code_ready  (code_ready),
    .code_is_eob (code_is_eob),
    .block_done  (block_done)
  );

  // Stub encoder: 0->0, 1..31 -> sym+6 (2->8, 3->9), above 31 -> FFFF.
  function automatic logic [15:0] enc_model(input logic [15:0] s);
    if (s > 16'd31) return 16'hFFFF;
    if (s == 16'd0) return 16'h0000;
    return s + 16'd6;
  endfunction

  assign enc_code = enc_model(enc_sym);

  typedef struct {
    logic [15:0] code;
    logic        eob;
    logic        fin;
  } exp_t;

  exp_t        exp_q [$];
  int          zz2r [64];
  logic [31:0] blk [64];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          hs_cnt = 0;
  int          done_cnt = 0;
  logic        bp_en = 1'b0;
  logic        bp_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
  int          bp_idx = 0;

  task automatic chk_b(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk_h(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_i(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Zigzag order built by walking anti-diagonals of the 8x8 grid.
  task automatic build_zigzag();
    int idx = 0;
    for (int s = 0; s < 15; s++) begin
      int lo = (s > 7) ? s - 7 : 0;
      int hi = (s < 7) ? s : 7;
      if (s % 2 == 0) begin
        for (int r = hi; r >= lo; r--) begin
          zz2r[idx] = r * 8 + (s - r);
          idx++;
        end
      end else begin
        for (int r = lo; r <= hi; r++) begin
          zz2r[idx] = r * 8 + (s - r);
          idx++;
        end
      end
    end
  endtask

  task automatic push_expected();
    int   last = 0;
    exp_t e;
    for (int k = 0; k < 64; k++) begin
      if (blk[zz2r[k]][31:16] != 16'd0) last = k;
    end
    for (int k = 0; k <= last; k++) begin
      e.code = enc_model(blk[zz2r[k]][31:16]);
      e.eob  = 1'b0;
      e.fin  = (k == 63);
      exp_q.push_back(e);
    end
    if (last < 63) begin
      e.code = 16'h000A;
      e.eob  = 1'b1;
      e.fin  = 1'b1;
      exp_q.push_back(e);
    end
  endtask

  task automatic fill(input logic [31:0] v);
    for (int i = 0; i < 64; i++) blk[i] = v;
  endtask

  task automatic load_block();
    for (int i = 0; i < 64; i++) begin
      int guard = 0;
      coef_in    = blk[i];
      coef_valid = 1'b1;
      while (!coef_ready && guard < 3000) begin
        @(posedge clk); #1;
        guard++;
      end
      if (!coef_ready) begin
        n_cmp++;
        n_bad++;
        $display("FAIL load_timeout: coef_ready low for %0d cycles, required 1", guard);
      end
      @(posedge clk); #1;
    end
    coef_valid = 1'b0;
    coef_in    = '0;
    push_expected();
  endtask

  task automatic wait_drain();
    int guard = 0;
    while ((exp_q.size() != 0 || code_valid) && guard < 3000) begin
      @(posedge clk); #1;
      guard++;
    end
    if (exp_q.size() != 0 || code_valid) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: %0d codes outstanding, required 0", exp_q.size());
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  always @(posedge clk) begin
    #1;
    if (bp_en) begin
      code_ready = bp_pat[bp_idx];
      bp_idx     = (bp_idx + 1) % 4;
    end else begin
      code_ready = 1'b1;
    end
  end

  logic        prev_stall = 1'b0;
  logic [15:0] prev_code;
  logic        prev_eob;

  always @(negedge clk) begin : cmp_proc
    exp_t e;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk_b("hold_valid", code_valid, 1'b1);
        chk_h("hold_code", code_out, prev_code);
        chk_b("hold_eob", code_is_eob, prev_eob);
      end
      if (code_valid && code_ready) begin
        hs_cnt++;
        if (block_done) done_cnt++;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_code: got %h with no code expected", code_out);
        end else begin
          e = exp_q.pop_front();
          chk_h("code_out", code_out, e.code);
          chk_b("code_is_eob", code_is_eob, e.eob);
          chk_b("block_done", block_done, e.fin);
          if (!e.fin) chk_b("coef_ready_busy", coef_ready, 1'b0);
        end
      end else begin
        chk_b("block_done_idle", block_done, 1'b0);
      end
      prev_stall = code_valid && !code_ready;
      prev_code  = code_out;
      prev_eob   = code_is_eob;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    build_zigzag();
    rst        = 1'b1;
    coef_in    = '0;
    coef_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_b("rst_code_valid", code_valid, 1'b0);
    chk_b("rst_coef_ready", coef_ready, 1'b1);
    chk_b("rst_block_done", block_done, 1'b0);
    chk_h("rst_enc_sym", enc_sym, 16'h0000);
    chk_h("rst_code_out", code_out, 16'h0000);
    chk_b("rst_code_is_eob", code_is_eob, 1'b0);
    rst = 1'b0;

    chk_i("zz_pos2", zz2r[2], 8);
    chk_i("zz_pos5", zz2r[5], 2);
    chk_i("zz_pos63", zz2r[63], 63);

    // All-zero block: DC then EOB.
    fill(32'h0);
    hs_cnt = 0; done_cnt = 0;
    load_block();
    chk_i("allzero_model_len", exp_q.size(), 2);
    wait_drain();
    chk_i("allzero_codes", hs_cnt, 2);
    chk_i("allzero_done", done_cnt, 1);

    // Dense block with first-code latency.
    fill(32'h0002_0000);
    hs_cnt = 0; done_cnt = 0;
    load_block();
    @(negedge clk); chk_b("lat_cycle1", code_valid, 1'b0);
    @(negedge clk); chk_b("lat_cycle2", code_valid, 1'b0);
    @(negedge clk); chk_b("lat_cycle3", code_valid, 1'b1);
    chk_h("dense_first_code", code_out, 16'h0008);
    wait_drain();
    chk_i("dense_codes", hs_cnt, 64);
    chk_i("dense_done", done_cnt, 1);

    // Sparse block: single nonzero at zigzag 2.
    fill(32'h0);
    blk[8] = 32'h0003_1234;
    hs_cnt = 0; done_cnt = 0;
    load_block();
    chk_i("sparse_model_len", exp_q.size(), 4);
    chk_h("sparse_model_zz2", exp_q[2].code, 16'h0009);
    chk_h("sparse_model_eob", exp_q[3].code, 16'h000A);
    wait_drain();
    chk_i("sparse_codes", hs_cnt, 4);
    chk_i("sparse_done", done_cnt, 1);

    // Dense block under backpressure.
    fill(32'h0002_0000);
    bp_en = 1'b1; bp_idx = 0;
    hs_cnt = 0; done_cnt = 0;
    load_block();
    wait_drain();
    bp_en = 1'b0;
    chk_i("bp_codes", hs_cnt, 64);
    chk_i("bp_done", done_cnt, 1);

    // Only raster 63 nonzero: full 64-code scan, no EOB.
    fill(32'h0);
    blk[63] = 32'h0001_0000;
    hs_cnt = 0; done_cnt = 0;
    load_block();
    chk_h("last63_model_code", exp_q[63].code, 16'h0007);
    wait_drain();
    chk_i("last63_codes", hs_cnt, 64);
    chk_i("last63_done", done_cnt, 1);

    // Reset in the middle of emitting a dense block.
    fill(32'h0002_0000);
    hs_cnt = 0; done_cnt = 0;
    load_block();
    begin
      int guard = 0;
      while (hs_cnt < 10 && guard < 500) begin
        @(posedge clk); #1;
        guard++;
      end
      chk_i("rst_mid_reached", hs_cnt, 10);
    end
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    chk_b("rst_mid_code_valid", code_valid, 1'b0);
    chk_b("rst_mid_coef_ready", coef_ready, 1'b1);
    chk_b("rst_mid_block_done", block_done, 1'b0);
    chk_i("rst_mid_done_cnt", done_cnt, 0);
    rst = 1'b0;
    fill(32'h0);
    hs_cnt = 0; done_cnt = 0;
    load_block();
    wait_drain();
    chk_i("post_rst_codes", hs_cnt, 2);
    chk_i("post_rst_done", done_cnt, 1);

    // Out-of-range symbol at DC.
    fill(32'h0);
    blk[0] = 32'h0040_0000;
    hs_cnt = 0; done_cnt = 0;
    load_block();
    chk_h("oor_model_code", exp_q[0].code, 16'hFFFF);
    wait_drain();
    chk_i("oor_codes", hs_cnt, 2);
    chk_i("oor_done", done_cnt, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
